pp_multi_parser: RTL and testbench

Multi-channel packet parser engine for the packet processing subsystem. Serves parse requests from `NUM_CH` register channels through round-robin arbitration, and reads each packet header from the input memory. Decodes the header with SEC-DED ECC, correcting single errors. Computes CRC8 over the payload, compares it with the stored CRC byte, and reports per-channel status through an interrupt pulse.

---
 rtl/pp_multi_parser.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_pp_multi_parser.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_multi_parser.sv
// ---------------------------------------------------------------------------
// pp_multi_parser
//
// Multi-channel packet parser engine. Parse requests arrive as one-cycle
// start pulses on NUM_CH channels and are served one at a time through a
// round-robin arbiter. For each job the engine reads the packet header word,
// checks/corrects its 8-bit {pkt_type, byte_cnt} field with a SEC-DED code,
// streams the payload bytes through a CRC8, compares against the stored CRC
// byte and reports per-channel status with a one-cycle interrupt pulse.
//
// Header word layout:
//   [31:16] data  [15:13] sop  [12] parity  [11:8] pkt_type
//   [7:4] byte_cnt  [3:0] ecc check bits
// Payload of byte_cnt+1 bytes sits at hdr+2 onward, CRC byte right after it.
//
// Optional feature macro:
//   PP_ECC_WRITEBACK_EN - when defined, a corrected header is written back to
//   memory (one extra WB cycle per corrected job). When undefined, there is
//   no WB state and mem_we / mem_wdata are tied to zero.
//
// Parameters:
//   NUM_CH   - number of request channels (1..8)
//   ADDR_W   - memory address width
//   CRC_POLY - CRC8 polynomial (init 0, MSB-first, no reflection/final XOR)
//
// Ports:
//   clk               - clock, all logic on rising edge
//   reset             - asynchronous active-low reset
//   pp_start          - per-channel start pulse
//   pp_addr_hdr       - per-channel header address, sampled at grant
//   pp_irq            - per-channel one-cycle done pulse
//   pp_pkt_crc_err    - per-channel CRC mismatch status
//   pp_pkt_ecc_corr   - per-channel corrected header error status
//   pp_pkt_ecc_uncorr - per-channel uncorrectable header error status
//   pp_pkt_byte_cnt   - per-channel corrected byte_cnt field (4 bits each)
//   pp_busy           - engine is not idle
//   mem_addr          - registered memory address
//   mem_we            - byte write enables
//   mem_wdata         - write data
//   mem_rdata         - read data for the current mem_addr (same cycle)
// ---------------------------------------------------------------------------
module pp_multi_parser #(
  parameter int         NUM_CH   = 4,
  parameter int         ADDR_W   = 14,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        pp_start,
  input  logic [NUM_CH*ADDR_W-1:0] pp_addr_hdr,
  output logic [NUM_CH-1:0]        pp_irq,
  output logic [NUM_CH-1:0]        pp_pkt_crc_err,
  output logic [NUM_CH-1:0]        pp_pkt_ecc_corr,
  output logic [NUM_CH-1:0]        pp_pkt_ecc_uncorr,
  output logic [NUM_CH*4-1:0]      pp_pkt_byte_cnt,
  output logic                     pp_busy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [3:0]               mem_we,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PLD  = 3'd2,
    S_CRC  = 3'd3,
    S_DONE = 3'd4
`ifdef PP_ECC_WRITEBACK_EN
    , S_WB = 3'd5
`endif
  } state_e;

  // Expected check bits for a data byte; a stored word is consistent when
  // its ecc field equals this value.
  function automatic logic [3:0] eccBits(input logic [7:0] d);
    logic [3:0] e;
    e[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    e[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    e[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    e[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return e;
  endfunction

  // Syndrome to single data-bit flip mask; zero when the syndrome does not
  // point at a data bit.
  function automatic logic [7:0] synToMask(input logic [3:0] s);
    logic [7:0] m;
    case (s)
      4'b0011: m = 8'h01;
      4'b0101: m = 8'h02;
      4'b0110: m = 8'h04;
      4'b0111: m = 8'h08;
      4'b1001: m = 8'h10;
      4'b1010: m = 8'h20;
      4'b1011: m = 8'h40;
      4'b1100: m = 8'h80;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // One byte of CRC8, MSB-first.
  function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  state_e state_q, state_d;

  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [CH_W-1:0]     ptr_q;
  logic [CH_W-1:0]     chSel_q;
  logic [ADDR_W-1:0]   hdrAddr_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [3:0]          cnt_q;
  logic [7:0]          crc_q;
  logic [3:0]          jobBcnt_q;
  logic                jobCorr_q;
  logic [NUM_CH-1:0]   crcErr_q;
  logic [NUM_CH-1:0]   eccCorr_q;
  logic [NUM_CH-1:0]   eccUncorr_q;
  logic [NUM_CH*4-1:0] byteCnt_q;

  logic                grantValid;
  logic [CH_W-1:0]     grantCh;
  logic                grantFire;
  logic [ADDR_W-1:0]   grantHdr;
  logic [ADDR_W-1:0]   hdrPlus2;

  logic [7:0]          rawD;
  logic [3:0]          syn;
  logic                pm;
  logic [7:0]          flipMask;
  logic                synOneHot;
  logic [7:0]          fixedD;
  logic                decCorr;
  logic                decUncorr;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_CH.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    grantValid = 1'b0;
    grantCh    = '0;
    idx        = 0;
    cand       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!grantValid && pending_q[cand]) begin
        grantValid = 1'b1;
        grantCh    = cand;
      end
    end
  end

  assign grantFire = (state_q == S_IDLE) && grantValid;
  assign grantHdr  = pp_addr_hdr[grantCh*ADDR_W +: ADDR_W];
  assign hdrPlus2  = hdrAddr_q + ADDR_W'(2);

  // A start on a channel that is pending or active simply re-arms the bit,
  // so a start landing on the grant or DONE cycle is served later.
  always_comb begin
    pending_d = pending_q;
    if (grantFire) pending_d[grantCh] = 1'b0;
    pending_d = pending_d | pp_start;
  end

  // Header SEC-DED decode on the word currently presented by memory.
  always_comb begin
    rawD      = mem_rdata[11:4];
    syn       = mem_rdata[3:0] ^ eccBits(rawD);
    pm        = mem_rdata[12] ^ (^rawD);
    flipMask  = synToMask(syn);
    synOneHot = (syn != 4'd0) && ((syn & (syn - 4'd1)) == 4'd0);
    fixedD    = rawD;
    decCorr   = 1'b0;
    decUncorr = 1'b0;
    if (syn == 4'd0) begin
      decCorr = pm;
    end else if (pm && (flipMask != 8'h00)) begin
      decCorr = 1'b1;
      fixedD  = rawD ^ flipMask;
    end else if (!pm && synOneHot) begin
      decCorr = 1'b1;
    end else begin
      decUncorr = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (grantValid) state_d = S_HDR;
      S_HDR: begin
        if (decUncorr) state_d = S_DONE;
`ifdef PP_ECC_WRITEBACK_EN
        else if (decCorr) state_d = S_WB;
`endif
        else state_d = S_PLD;
      end
`ifdef PP_ECC_WRITEBACK_EN
      S_WB:   state_d = S_PLD;
`endif
      S_PLD:  if (cnt_q == jobBcnt_q) state_d = S_CRC;
      S_CRC:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; decoded from state so reset clears them asynchronously.
  always_comb begin
    pp_irq  = '0;
    pp_busy = (state_q != S_IDLE);
    mem_we  = 4'b0000;
    case (state_q)
      S_DONE: pp_irq[chSel_q] = 1'b1;
`ifdef PP_ECC_WRITEBACK_EN
      S_WB:   mem_we = 4'b1111;
`endif
      default: ;
    endcase
  end

`ifdef PP_ECC_WRITEBACK_EN
  logic [31:0] wdata_q;
`else
  logic unusedRdata;
  assign unusedRdata = ^mem_rdata[31:13];
`endif

  // Job datapath: arbitration bookkeeping, address walk, CRC and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      ptr_q       <= '0;
      chSel_q     <= '0;
      hdrAddr_q   <= '0;
      memAddr_q   <= '0;
      cnt_q       <= '0;
      crc_q       <= '0;
      jobBcnt_q   <= '0;
      jobCorr_q   <= 1'b0;
      crcErr_q    <= '0;
      eccCorr_q   <= '0;
      eccUncorr_q <= '0;
      byteCnt_q   <= '0;
`ifdef PP_ECC_WRITEBACK_EN
      wdata_q     <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (grantValid) begin
            chSel_q   <= grantCh;
            hdrAddr_q <= grantHdr;
            memAddr_q <= grantHdr;
            if (grantCh == CH_W'(NUM_CH - 1)) ptr_q <= '0;
            else                              ptr_q <= grantCh + 1'b1;
            crcErr_q[grantCh]              <= 1'b0;
            eccCorr_q[grantCh]             <= 1'b0;
            eccUncorr_q[grantCh]           <= 1'b0;
            byteCnt_q[grantCh*4 +: 4]      <= 4'd0;
          end
        end
        S_HDR: begin
          jobBcnt_q <= fixedD[3:0];
          jobCorr_q <= decCorr;
          crc_q     <= 8'h00;
          cnt_q     <= 4'd0;
          if (decUncorr) begin
            eccUncorr_q[chSel_q] <= 1'b1;
`ifdef PP_ECC_WRITEBACK_EN
          end else if (decCorr) begin
            // Keep the upper fields, rebuild parity/data/ecc from corrected d.
            wdata_q <= {mem_rdata[31:13], ^fixedD, fixedD, eccBits(fixedD)};
`endif
          end else begin
            memAddr_q <= hdrPlus2;
          end
        end
`ifdef PP_ECC_WRITEBACK_EN
        S_WB: begin
          memAddr_q <= hdrPlus2;
        end
`endif
        S_PLD: begin
          crc_q     <= crc8Step(crc_q, mem_rdata[7:0]);
          cnt_q     <= cnt_q + 4'd1;
          memAddr_q <= memAddr_q + ADDR_W'(1);
        end
        S_CRC: begin
          crcErr_q[chSel_q]          <= (mem_rdata[7:0] != crc_q);
          eccCorr_q[chSel_q]         <= jobCorr_q;
          byteCnt_q[chSel_q*4 +: 4]  <= jobBcnt_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr          = memAddr_q;
  assign pp_pkt_crc_err    = crcErr_q;
  assign pp_pkt_ecc_corr   = eccCorr_q;
  assign pp_pkt_ecc_uncorr = eccUncorr_q;
  assign pp_pkt_byte_cnt   = byteCnt_q;

`ifdef PP_ECC_WRITEBACK_EN
  assign mem_wdata = wdata_q;
`else
  assign mem_wdata = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pp_multi_parser.sv
// ---------------------------------------------------------------------------
// tb_pp_multi_parser
//
// Directed bench for pp_multi_parser with a word-addressed memory model.
// Expected job results are pushed to a scoreboard queue as each request is
// issued and popped when the matching irq pulse appears; the irq position
// is checked against the expected cycle latency. Header ecc and CRC bytes for
// extra packets come from small reference functions written from the
// header/CRC definitions. Honours PP_ECC_WRITEBACK_EN for the writeback case.
// ---------------------------------------------------------------------------
module tb_pp_multi_parser;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 14;
`ifdef PP_ECC_WRITEBACK_EN
  localparam int WB_EXTRA = 1;
`else
  localparam int WB_EXTRA = 0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        pp_start;
  logic [NUM_CH*ADDR_W-1:0] pp_addr_hdr;
  logic [NUM_CH-1:0]        pp_irq;
  logic [NUM_CH-1:0]        pp_pkt_crc_err;
  logic [NUM_CH-1:0]        pp_pkt_ecc_corr;
  logic [NUM_CH-1:0]        pp_pkt_ecc_uncorr;
  logic [NUM_CH*4-1:0]      pp_pkt_byte_cnt;
  logic                     pp_busy;
  logic [ADDR_W-1:0]        mem_addr;
  logic [3:0]               mem_we;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  typedef struct {
    int         ch;
    int         lat;
    logic       crcErr;
    logic       corr;
    logic       uncorr;
    logic [3:0] bcnt;
  } exp_t;

  exp_t sbQueue[$];

  int               checks = 0;
  int               errors = 0;
  int               writeCount;
  logic [ADDR_W-1:0] lastWaddr;
  logic [31:0]      lastWdata;
  logic [ADDR_W-1:0] maxAddr;

  pp_multi_parser #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .CRC_POLY(8'h07)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pp_start         (pp_start),
    .pp_addr_hdr      (pp_addr_hdr),
    .pp_irq           (pp_irq),
    .pp_pkt_crc_err   (pp_pkt_crc_err),
    .pp_pkt_ecc_corr  (pp_pkt_ecc_corr),
    .pp_pkt_ecc_uncorr(pp_pkt_ecc_uncorr),
    .pp_pkt_byte_cnt  (pp_pkt_byte_cnt),
    .pp_busy          (pp_busy),
    .mem_addr         (mem_addr),
    .mem_we           (mem_we),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  function automatic logic [7:0] refCrc(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] r;
    r = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
      else      r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [31:0] refHdr(input logic [3:0] ptype, input logic [3:0] bcnt);
    logic [7:0] d;
    logic [3:0] e;
    d    = {ptype, bcnt};
    e[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    e[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    e[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    e[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {16'h0000, 3'b000, ^d, d, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic putPacket(input logic [ADDR_W-1:0] base, input logic [3:0] ptype,
                           input logic [3:0] bcnt, input logic [7:0] firstByte,
                           input logic crcBad);
    logic [7:0] crc;
    logic [7:0] b;
    crc = 8'h00;
    mem[base] = refHdr(ptype, bcnt);
    for (int i = 0; i <= int'(bcnt); i++) begin
      b = firstByte + 8'(i);
      mem[base + ADDR_W'(2 + i)] = {24'h0, b};
      crc = refCrc(crc, b);
    end
    mem[base + ADDR_W'(int'(bcnt) + 3)] = {24'h0, crc ^ {7'b0, crcBad}};
  endtask

  task automatic setHdr(input int ch, input logic [ADDR_W-1:0] addr);
    pp_addr_hdr[ch*ADDR_W +: ADDR_W] = addr;
  endtask

  task automatic pushExp(input int ch, input int lat, input logic crcErr,
                         input logic corr, input logic uncorr, input logic [3:0] bcnt);
    exp_t e;
    e.ch = ch; e.lat = lat; e.crcErr = crcErr; e.corr = corr; e.uncorr = uncorr; e.bcnt = bcnt;
    sbQueue.push_back(e);
  endtask

  // Called at a negedge; pulses the start mask for exactly one clock.
  task automatic applyStimulus(input logic [NUM_CH-1:0] mask);
    pp_start = mask;
    @(negedge clk);
    pp_start = '0;
  endtask

  // Waits for the next irq (bounded), applying writes to the memory model,
  // then pops the scoreboard and compares pulse, latency and status.
  task automatic checkOutput(input string tag, input int budget);
    exp_t e;
    int   k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (mem_we != 4'b0000) begin
        writeCount++;
        lastWaddr = mem_addr;
        lastWdata = mem_wdata;
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
      if (pp_busy && mem_addr > maxAddr) maxAddr = mem_addr;
    end while (pp_irq == '0 && k < budget);
    check({tag, "_irqSeen"}, {31'b0, pp_irq != '0}, 32'd1);
    if (pp_irq != '0 && sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      check({tag, "_irqVec"},  32'(pp_irq), 32'(1 << e.ch));
      check({tag, "_latency"}, 32'(k), 32'(e.lat));
      check({tag, "_crcErr"},  {31'b0, pp_pkt_crc_err[e.ch]}, {31'b0, e.crcErr});
      check({tag, "_eccCorr"}, {31'b0, pp_pkt_ecc_corr[e.ch]}, {31'b0, e.corr});
      check({tag, "_eccUncorr"}, {31'b0, pp_pkt_ecc_uncorr[e.ch]}, {31'b0, e.uncorr});
      if (!e.uncorr)
        check({tag, "_byteCnt"}, {28'b0, pp_pkt_byte_cnt[e.ch*4 +: 4]}, {28'b0, e.bcnt});
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wc0;
    int extra;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'h0;
    reset       = 1'b0;
    pp_start    = '0;
    pp_addr_hdr = '0;
    writeCount  = 0;
    maxAddr     = '0;
    lastWaddr   = '0;
    lastWdata   = '0;
    setHdr(0, 14'h010);
    setHdr(1, 14'h040);
    setHdr(2, 14'h080);
    setHdr(3, 14'h0C0);

    mem[14'h010] = 32'h0000_1326;
    mem[14'h012] = 32'h01;
    mem[14'h013] = 32'h02;
    mem[14'h014] = 32'h03;
    mem[14'h015] = 32'h48;

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    check("rst_irq",     32'(pp_irq), 32'h0);
    check("rst_busy",    {31'b0, pp_busy}, 32'h0);
    check("rst_memAddr", 32'(mem_addr), 32'h0);
    check("rst_memWe",   32'(mem_we), 32'h0);
    check("rst_wdata",   mem_wdata, 32'h0);
    check("rst_crcErr",  32'(pp_pkt_crc_err), 32'h0);
    check("rst_corr",    32'(pp_pkt_ecc_corr), 32'h0);
    check("rst_uncorr",  32'(pp_pkt_ecc_uncorr), 32'h0);
    check("rst_byteCnt", 32'(pp_pkt_byte_cnt), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] clean packet ch0");
    wc0 = writeCount;
    pushExp(0, 6, 1'b0, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0001);
    checkOutput("clean", 40);
    check("clean_writes", 32'(writeCount - wc0), 32'd0);
    @(negedge clk);
    check("clean_irqPulse", 32'(pp_irq), 32'h0);
    check("clean_idle", {31'b0, pp_busy}, 32'h0);
    check("clean_held", {28'b0, pp_pkt_byte_cnt[3:0]}, 32'd2);

    $display("[TB] bad CRC byte");
    mem[14'h015] = 32'h49;
    pushExp(0, 6, 1'b1, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0001);
    checkOutput("crcBad", 40);
    @(negedge clk);

    $display("[TB] single data-bit error");
    mem[14'h015] = 32'h48;
    mem[14'h010] = 32'h0000_1306;
    wc0 = writeCount;
    pushExp(0, 6 + WB_EXTRA, 1'b0, 1'b1, 1'b0, 4'd2);
    applyStimulus(4'b0001);
    checkOutput("corr", 40);
    check("corr_writes", 32'(writeCount - wc0), 32'(WB_EXTRA));
`ifdef PP_ECC_WRITEBACK_EN
    check("corr_wbAddr", 32'(lastWaddr), 32'h010);
    check("corr_wbData", lastWdata, 32'h0000_1326);
`endif
    @(negedge clk);

    $display("[TB] double error");
    mem[14'h010] = 32'h0000_1316;
    maxAddr = '0;
    pushExp(0, 2, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(4'b0001);
    checkOutput("uncorr", 20);
    check("uncorr_maxAddr", 32'(maxAddr), 32'h010);
    mem[14'h010] = 32'h0000_1326;
    @(negedge clk);

    $display("[TB] round robin");
    putPacket(14'h040, 4'd5, 4'd0, 8'hA5, 1'b0);
    putPacket(14'h080, 4'd1, 4'd4, 8'h30, 1'b1);
    pushExp(1, 4, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0010);
    checkOutput("ch1", 40);
    @(negedge clk);
    pushExp(2, 8, 1'b1, 1'b0, 1'b0, 4'd4);
    pushExp(0, 7, 1'b0, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0101);
    checkOutput("arbCh2", 60);
    checkOutput("arbCh0", 60);

    $display("[TB] start during DONE");
    pushExp(0, 6, 1'b0, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0001);
    checkOutput("doneStart", 40);
    check("held_ch2Crc", {31'b0, pp_pkt_crc_err[2]}, 32'd1);
    check("held_ch2Cnt", {28'b0, pp_pkt_byte_cnt[11:8]}, 32'd4);
    @(negedge clk);

    $display("[TB] reset during payload");
    applyStimulus(4'b0001);
    @(negedge clk);
    @(negedge clk);
    pp_start = 4'b0010;
    @(negedge clk);
    pp_start = '0;
    check("rstMid_busy", {31'b0, pp_busy}, 32'd1);
    check("rstMid_addr", 32'(mem_addr), 32'h013);
    reset = 1'b0;
    #1;
    check("rstMid_busy0",  {31'b0, pp_busy}, 32'h0);
    check("rstMid_irq",    32'(pp_irq), 32'h0);
    check("rstMid_addr0",  32'(mem_addr), 32'h0);
    check("rstMid_we",     32'(mem_we), 32'h0);
    check("rstMid_wdata",  mem_wdata, 32'h0);
    check("rstMid_crcErr", 32'(pp_pkt_crc_err), 32'h0);
    check("rstMid_corr",   32'(pp_pkt_ecc_corr), 32'h0);
    check("rstMid_uncorr", 32'(pp_pkt_ecc_uncorr), 32'h0);
    check("rstMid_cnt",    32'(pp_pkt_byte_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pushExp(0, 6, 1'b0, 1'b0, 1'b0, 4'd2);
    applyStimulus(4'b0001);
    checkOutput("postRst", 40);
    extra = 0;
    repeat (16) begin
      @(negedge clk);
      if (pp_irq != '0) extra++;
    end
    check("postRst_noStaleJob", 32'(extra), 32'd0);
    check("postRst_idle", {31'b0, pp_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
